// File: rtl/iec_pkg.sv
// Shared IEC command opcodes, device FSM states and decoded command kinds.
package iec_pkg;

  localparam logic [2:0] CMD_LISTEN = 3'b001;
  localparam logic [2:0] CMD_TALK   = 3'b010;
  localparam logic [3:0] CMD_SECOND = 4'h6;
  localparam logic [3:0] CMD_CLOSE  = 4'hE;
  localparam logic [3:0] CMD_OPEN   = 4'hF;
  localparam logic [7:0] UNLISTEN   = 8'h3F;
  localparam logic [7:0] UNTALK     = 8'h5F;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StCmd        = 3'd1,
    StListenData = 3'd2,
    StTurnaround = 3'd3,
    StTalkWait   = 3'd4,
    StTalkBusy   = 3'd5
  } dev_state_e;

  typedef enum logic [2:0] {
    KindNone,
    KindListen,
    KindUnlisten,
    KindTalk,
    KindUntalk,
    KindSecond,
    KindClose,
    KindOpen
  } cmd_kind_e;

endpackage

// File: rtl/iec_cmd_decode.sv
// Combinational ATN command byte classifier: kind, primary address match, channel.
module iec_cmd_decode
  import iec_pkg::*;
#(
  parameter int unsigned DEV_ADDR = 8
) (
  input  logic [7:0] cmd_byte,
  output cmd_kind_e  kind,
  output logic       addr_match,
  output logic [3:0] ch
);

  localparam logic [4:0] DevAddr = DEV_ADDR[4:0];

  assign addr_match = (cmd_byte[4:0] == DevAddr);
  assign ch         = cmd_byte[3:0];

  // UNLISTEN/UNTALK share the LISTEN/TALK prefix, so they are matched first.
  always_comb begin
    kind = KindNone;
    if (cmd_byte == UNLISTEN) begin
      kind = KindUnlisten;
    end else if (cmd_byte == UNTALK) begin
      kind = KindUntalk;
    end else if (cmd_byte[7:5] == CMD_LISTEN) begin
      kind = KindListen;
    end else if (cmd_byte[7:5] == CMD_TALK) begin
      kind = KindTalk;
    end else if (cmd_byte[7:4] == CMD_SECOND) begin
      kind = KindSecond;
    end else if (cmd_byte[7:4] == CMD_CLOSE) begin
      kind = KindClose;
    end else if (cmd_byte[7:4] == CMD_OPEN) begin
      kind = KindOpen;
    end
  end

endmodule

// File: rtl/iec_dev_ctrl.sv
// Device-side IEC command sequencer: ATN command decode, listener data routing,
// listener->talker turnaround and talker byte streaming.
module iec_dev_ctrl
  import iec_pkg::*;
#(
  parameter int unsigned DEV_ADDR = 8,
  parameter int unsigned TURN_CYC = 80
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       atn,
  input  logic [7:0] rx_byte,
  input  logic       rx_ready,
  input  logic       rx_eoi,
  output logic [7:0] tx_byte,
  output logic       tx_ready,
  input  logic       tx_done,
  input  logic       src_valid,
  input  logic [7:0] src_byte,
  input  logic       src_last,
  output logic       src_ack,
  output logic       tx_eoi,
  output logic       dat_valid,
  output logic [7:0] dat_byte,
  output logic       dat_eoi,
  output logic [3:0] sec_addr,
  output logic       open_stb,
  output logic       close_stb,
  output logic       listening,
  output logic       talking
);

  localparam int unsigned CntW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TURN_CYC - 1);

  dev_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0] tx_byte_q, tx_byte_d, dat_byte_q, dat_byte_d;
  logic [3:0] sec_addr_q, sec_addr_d;
  logic tx_ready_q, tx_ready_d, src_ack_q, src_ack_d, tx_eoi_q, tx_eoi_d;
  logic dat_valid_q, dat_valid_d, dat_eoi_q, dat_eoi_d;
  logic open_q, open_d, close_q, close_d;
  logic listening_q, listening_d, talking_q, talking_d;

  cmd_kind_e  dec_kind;
  logic       dec_match;
  logic [3:0] dec_ch;

  iec_cmd_decode #(
    .DEV_ADDR (DEV_ADDR)
  ) u_cmd_decode (
    .cmd_byte   (rx_byte),
    .kind       (dec_kind),
    .addr_match (dec_match),
    .ch         (dec_ch)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_byte_d   = tx_byte_q;
    tx_eoi_d    = tx_eoi_q;
    tx_ready_d  = 1'b0;
    src_ack_d   = 1'b0;
    dat_valid_d = 1'b0;
    dat_byte_d  = dat_byte_q;
    dat_eoi_d   = dat_eoi_q;
    sec_addr_d  = sec_addr_q;
    open_d      = 1'b0;
    close_d     = 1'b0;
    listening_d = listening_q;
    talking_d   = talking_q;

    // ATN pre-empts everything: any byte or tx_done seen this cycle is discarded.
    if (atn && (state_q != StCmd)) begin
      state_d = StCmd;
    end else begin
      case (state_q)
        StIdle: ;
        StCmd: begin
          if (rx_ready) begin
            case (dec_kind)
              KindListen: begin
                listening_d = dec_match;
                if (dec_match) talking_d = 1'b0;
              end
              KindUnlisten: listening_d = 1'b0;
              KindTalk: begin
                talking_d = dec_match;
                if (dec_match) listening_d = 1'b0;
              end
              KindUntalk: talking_d = 1'b0;
              KindSecond, KindClose, KindOpen: begin
                if (listening_q || talking_q) begin
                  sec_addr_d = dec_ch;
                  close_d    = (dec_kind == KindClose);
                  open_d     = (dec_kind == KindOpen);
                end
              end
              default: ;
            endcase
          end
          if (!atn) begin
            if (listening_q) begin
              state_d = StListenData;
            end else if (talking_q) begin
              state_d = StTurnaround;
              cnt_d   = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StListenData: begin
          if (rx_ready) begin
            dat_valid_d = 1'b1;
            dat_byte_d  = rx_byte;
            dat_eoi_d   = rx_eoi;
          end
        end
        StTurnaround: begin
          if (cnt_q == CntLast) begin
            state_d = StTalkWait;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StTalkWait: begin
          if (src_valid) begin
            tx_byte_d  = src_byte;
            tx_eoi_d   = src_last;
            tx_ready_d = 1'b1;
            src_ack_d  = 1'b1;
            state_d    = StTalkBusy;
          end
        end
        StTalkBusy: begin
          if (tx_done) begin
            if (tx_eoi_q) begin
              talking_d = 1'b0;
              state_d   = StIdle;
            end else begin
              state_d = StTalkWait;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tx_byte_q   <= '0;
      tx_eoi_q    <= 1'b0;
      tx_ready_q  <= 1'b0;
      src_ack_q   <= 1'b0;
      dat_valid_q <= 1'b0;
      dat_byte_q  <= '0;
      dat_eoi_q   <= 1'b0;
      sec_addr_q  <= '0;
      open_q      <= 1'b0;
      close_q     <= 1'b0;
      listening_q <= 1'b0;
      talking_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_byte_q   <= tx_byte_d;
      tx_eoi_q    <= tx_eoi_d;
      tx_ready_q  <= tx_ready_d;
      src_ack_q   <= src_ack_d;
      dat_valid_q <= dat_valid_d;
      dat_byte_q  <= dat_byte_d;
      dat_eoi_q   <= dat_eoi_d;
      sec_addr_q  <= sec_addr_d;
      open_q      <= open_d;
      close_q     <= close_d;
      listening_q <= listening_d;
      talking_q   <= talking_d;
    end
  end

  assign tx_byte   = tx_byte_q;
  assign tx_ready  = tx_ready_q;
  assign src_ack   = src_ack_q;
  assign tx_eoi    = tx_eoi_q;
  assign dat_valid = dat_valid_q;
  assign dat_byte  = dat_byte_q;
  assign dat_eoi   = dat_eoi_q;
  assign sec_addr  = sec_addr_q;
  assign open_stb  = open_q;
  assign close_stb = close_q;
  assign listening = listening_q;
  assign talking   = talking_q;

endmodule

// File: tb/tb_iec_dev_ctrl.sv
// Scoreboard bench for iec_dev_ctrl: directed ATN/listener/talker sequences, strobes
// checked against a queue of expected events by a negedge monitor.
module tb_iec_dev_ctrl;

  localparam int unsigned DevAddr = 8;
  localparam int unsigned TurnCyc = 80;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       atn = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_eoi = 1'b0;
  logic       tx_done = 1'b0;
  logic       src_valid = 1'b0;
  logic [7:0] src_byte = 8'h00;
  logic       src_last = 1'b0;
  logic [7:0] tx_byte, dat_byte;
  logic [3:0] sec_addr;
  logic       tx_ready, src_ack, tx_eoi, dat_valid, dat_eoi;
  logic       open_stb, close_stb, listening, talking;

  typedef enum logic [1:0] {EvDat, EvTx, EvOpen, EvClose} ev_e;
  typedef struct packed {
    ev_e        kind;
    logic [7:0] data;
    logic       eoi;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  iec_dev_ctrl #(
    .DEV_ADDR (DevAddr),
    .TURN_CYC (TurnCyc)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .atn       (atn),
    .rx_byte   (rx_byte),
    .rx_ready  (rx_ready),
    .rx_eoi    (rx_eoi),
    .tx_byte   (tx_byte),
    .tx_ready  (tx_ready),
    .tx_done   (tx_done),
    .src_valid (src_valid),
    .src_byte  (src_byte),
    .src_last  (src_last),
    .src_ack   (src_ack),
    .tx_eoi    (tx_eoi),
    .dat_valid (dat_valid),
    .dat_byte  (dat_byte),
    .dat_eoi   (dat_eoi),
    .sec_addr  (sec_addr),
    .open_stb  (open_stb),
    .close_stb (close_stb),
    .listening (listening),
    .talking   (talking)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input ev_e kind, input logic [7:0] data, input logic eoi);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.eoi  = eoi;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input string name, input ev_e kind, input logic [7:0] data,
                         input logic eoi);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected strobe data %0h eoi %0b, none expected", name, data, eoi);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.data !== data || e.eoi !== eoi) begin
        errors++;
        $display("FAIL %s: got kind %0d data %0h eoi %0b expected kind %0d data %0h eoi %0b",
                 name, kind, data, eoi, e.kind, e.data, e.eoi);
      end
    end
  endtask

  // Monitor: outputs change on posedge, so negedge sampling is stable.
  always @(negedge clk) begin
    if (reset_n) begin
      if (dat_valid) pop_cmp("dat_valid", EvDat, dat_byte, dat_eoi);
      if (tx_ready) pop_cmp("tx_ready", EvTx, tx_byte, tx_eoi);
      if (src_ack || tx_ready) check("src_ack_pairs_tx_ready", 32'(src_ack), 32'(tx_ready));
      if (open_stb) pop_cmp("open_stb", EvOpen, {4'h0, sec_addr}, 1'b0);
      if (close_stb) pop_cmp("close_stb", EvClose, {4'h0, sec_addr}, 1'b0);
    end
  end

  function automatic logic [31:0] out_vec();
    return {3'b000, tx_byte, tx_ready, src_ack, tx_eoi, dat_valid, dat_byte, dat_eoi,
            sec_addr, open_stb, close_stb, listening, talking};
  endfunction

  task automatic send_rx(input logic [7:0] b, input logic eoi);
    @(negedge clk);
    rx_byte  = b;
    rx_eoi   = eoi;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    rx_eoi   = 1'b0;
  endtask

  task automatic set_atn(input logic v);
    @(negedge clk);
    atn = v;
    @(negedge clk);
  endtask

  task automatic wait_ack(input string name, input int bound, output int lat);
    lat = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (src_ack) break;
    end
    check(name, 32'(src_ack), 32'd1);
  endtask

  task automatic pulse_done();
    repeat (2) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic src_send(input logic [7:0] b, input logic last);
    int lat;
    push(EvTx, b, last);
    @(negedge clk);
    src_valid = 1'b1;
    src_byte  = b;
    src_last  = last;
    wait_ack("src_ack_seen", 20, lat);
    @(negedge clk);
    src_valid = 1'b0;
    src_last  = 1'b0;
  endtask

  task automatic count_acks(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (src_ack) n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Listener: LISTEN 8, SECOND 15, two data bytes, second with EOI
    set_atn(1'b1);
    send_rx(8'h28, 1'b0);
    check("listen_set", 32'(listening), 32'd1);
    send_rx(8'h6F, 1'b0);
    check("sec_addr_f", 32'(sec_addr), 32'hF);
    set_atn(1'b0);
    push(EvDat, 8'h41, 1'b0);
    push(EvDat, 8'h42, 1'b1);
    send_rx(8'h41, 1'b0);
    send_rx(8'h42, 1'b1);
    check("still_listening", 32'(listening), 32'd1);

    // Other device addressed: listener dropped, SECOND ignored, IDLE drops data
    set_atn(1'b1);
    send_rx(8'h29, 1'b0);
    check("listen_other_clears", 32'(listening), 32'd0);
    send_rx(8'h60, 1'b0);
    check("second_ignored", 32'(sec_addr), 32'hF);
    set_atn(1'b0);
    send_rx(8'h41, 1'b0);
    send_rx(8'h43, 1'b1);
    check("idle_not_talking", 32'(talking), 32'd0);

    // OPEN / SECOND / CLOSE / UNLISTEN while addressed as listener
    set_atn(1'b1);
    send_rx(8'h28, 1'b0);
    push(EvOpen, 8'h02, 1'b0);
    send_rx(8'hF2, 1'b0);
    check("open_sec_addr", 32'(sec_addr), 32'h2);
    send_rx(8'h67, 1'b0);
    check("second_sec_addr", 32'(sec_addr), 32'h7);
    push(EvClose, 8'h02, 1'b0);
    send_rx(8'hE2, 1'b0);
    check("close_sec_addr", 32'(sec_addr), 32'h2);
    send_rx(8'h3F, 1'b0);
    check("unlisten", 32'(listening), 32'd0);
    set_atn(1'b0);

    // Talker: TALK 8, SECOND 2, turnaround then three source bytes
    set_atn(1'b1);
    send_rx(8'h48, 1'b0);
    check("talk_set", 32'(talking), 32'd1);
    check("talk_not_listen", 32'(listening), 32'd0);
    send_rx(8'h62, 1'b0);
    check("talk_sec_addr", 32'(sec_addr), 32'h2);
    push(EvTx, 8'h11, 1'b0);
    @(negedge clk);
    atn       = 1'b0;
    src_valid = 1'b1;
    src_byte  = 8'h11;
    src_last  = 1'b0;
    @(posedge clk);
    // TURN_CYC cycles in TURNAROUND, then one cycle in TALK_WAIT registers the strobe.
    wait_ack("turn_ack_seen", int'(TurnCyc) + 20, lat);
    check("turn_latency", 32'(lat), 32'(TurnCyc + 1));
    @(negedge clk);
    src_valid = 1'b0;
    pulse_done();
    src_send(8'h22, 1'b0);
    pulse_done();
    check("talking_mid_stream", 32'(talking), 32'd1);
    src_send(8'h33, 1'b1);
    pulse_done();
    check("talk_done_clears", 32'(talking), 32'd0);

    // ATN re-asserted on the same cycle as tx_done while TALK_BUSY
    set_atn(1'b1);
    send_rx(8'h48, 1'b0);
    send_rx(8'h6C, 1'b0);
    check("talk2_sec_addr", 32'(sec_addr), 32'hC);
    push(EvTx, 8'h77, 1'b0);
    @(negedge clk);
    atn       = 1'b0;
    src_valid = 1'b1;
    src_byte  = 8'h77;
    src_last  = 1'b0;
    wait_ack("talk2_ack_seen", int'(TurnCyc) + 20, lat);
    @(negedge clk);
    src_byte = 8'h78;
    @(negedge clk);
    atn     = 1'b1;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    count_acks(6, n);
    check("abort_no_src_ack", 32'(n), 32'd0);
    check("abort_talking_held", 32'(talking), 32'd1);
    send_rx(8'h5F, 1'b0);
    check("untalk_in_cmd", 32'(talking), 32'd0);
    src_valid = 1'b0;
    set_atn(1'b0);

    // Asynchronous reset while TALK_BUSY
    set_atn(1'b1);
    send_rx(8'h48, 1'b0);
    push(EvTx, 8'h99, 1'b1);
    @(negedge clk);
    atn       = 1'b0;
    src_valid = 1'b1;
    src_byte  = 8'h99;
    src_last  = 1'b1;
    wait_ack("talk3_ack_seen", int'(TurnCyc) + 20, lat);
    @(negedge clk);
    src_valid = 1'b0;
    src_last  = 1'b0;
    check("busy_talking", 32'(talking), 32'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", out_vec(), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    // After reset the FSM is IDLE: data, tx_done and source bytes are all ignored.
    send_rx(8'h41, 1'b0);
    pulse_done();
    @(negedge clk);
    src_valid = 1'b1;
    src_byte  = 8'h55;
    count_acks(TurnCyc + 10, n);
    check("idle_no_src_ack", 32'(n), 32'd0);
    check("idle_flags", {30'h0, listening, talking}, 32'h0);
    src_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
